// File: rtl/v_store_seq.sv
// Vector store sequencer: spreads a latched register group over NUM_BANKS 32-bit memory banks.
// Optional feature macro VSU_MASK_EN adds the per-element write mask input vmask.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 16
`endif
module v_store_seq #(
  parameter int VLEN      = 128,
  parameter int NUM_BANKS = 4,
  parameter int ADDR_BITS = `DATAMEM_BITS
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                store_op,
  input  logic [2:0]                vsew,
  input  logic [2:0]                lmul,
  input  logic [ADDR_BITS-1:0]      base_addr,
  input  logic [ADDR_BITS-1:0]      stride,
  input  logic [4*VLEN-1:0]         data,
`ifdef VSU_MASK_EN
  input  logic [4*VLEN/8-1:0]       vmask,
`endif
  input  logic                      mem_stall,
  output logic [NUM_BANKS-1:0]      bank_we,
  output logic [NUM_BANKS*ADDR_BITS-1:0] bank_addr,
  output logic [NUM_BANKS*32-1:0]   bank_wdata,
  output logic [NUM_BANKS*4-1:0]    bank_be,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                dbg_state
);
  // Handshake: a request is taken on a posedge with req_valid && req_ready; req_ready is high only in IDLE.
  localparam int CW = $clog2(VLEN/2 + NUM_BANKS + 1);
  localparam logic [ADDR_BITS-1:0] BMASK = ADDR_BITS'(NUM_BANKS-1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic                  unit_q, err_q;
  logic [1:0]            sew_q;
  logic [CW-1:0]         total_q, idx_q, idx_d;
  logic [ADDR_BITS-1:0]  base_q, stride_q, addr_q, addr_d;
  logic [4*VLEN-1:0]     data_q;
`ifdef VSU_MASK_EN
  logic [4*VLEN/8-1:0]   vmask_q, mw;
`endif

  logic                  accept, bad;
  logic [CW-1:0]         cnt, k;
  logic [ADDR_BITS-1:0]  a, bk;
  logic [NUM_BANKS-1:0]  used;
  logic                  stop, hit, en;
  logic [31:0]           word;
  logic [3:0]            be;

  function automatic logic [31:0] get_elem(input logic [4*VLEN-1:0] d, input logic [1:0] sew,
                                           input logic [CW-1:0] e);
    logic [4*VLEN-1:0] sh;
    sh = d >> (32'(e) << (32'(3) + 32'(sew)));
    case (sew)
      2'd0:    return {24'b0, sh[7:0]};
      2'd1:    return {16'b0, sh[15:0]};
      default: return sh[31:0];
    endcase
  endfunction

  assign accept    = (state_q == IDLE) && req_valid;
  assign bad       = store_op[1] | (vsew > 3'd2) | (lmul > 3'd2);
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = (state_q == DONE) && err_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      unit_q   <= 1'b0;
      err_q    <= 1'b0;
      sew_q    <= '0;
      total_q  <= '0;
      idx_q    <= '0;
      base_q   <= '0;
      stride_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
`ifdef VSU_MASK_EN
      vmask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      if (accept) begin
        unit_q   <= (store_op == 2'd0);
        err_q    <= bad;
        sew_q    <= vsew[1:0];
        // Unit-stride counts 32-bit words, strided counts elements.
        total_q  <= (store_op == 2'd0) ? CW'((VLEN/32) << lmul[1:0])
                                       : CW'((VLEN >> (3 + vsew[1:0])) << lmul[1:0]);
        base_q   <= base_addr;
        stride_q <= stride;
        data_q   <= data;
`ifdef VSU_MASK_EN
        vmask_q  <= vmask;
`endif
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    bank_we    = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    bank_be    = '0;
    cnt        = '0;
    k          = '0;
    a          = addr_q;
    bk         = '0;
    used       = '0;
    stop       = 1'b0;
    hit        = 1'b0;
    en         = 1'b1;
    word       = '0;
    be         = '0;
`ifdef VSU_MASK_EN
    mw         = '0;
`endif
    case (state_q)
      IDLE: begin
        idx_d  = '0;
        addr_d = base_addr;
        if (req_valid) state_d = bad ? DONE : ISSUE;
      end
      ISSUE: begin
        if (unit_q) begin
          for (int j = 0; j < NUM_BANKS; j++) begin
            k = idx_q + CW'(j);
            if (k < total_q) begin
              a    = base_q + ADDR_BITS'(k);
              bk   = a & BMASK;
              word = get_elem(data_q, 2'd2, k);
              be   = 4'hF;
`ifdef VSU_MASK_EN
              mw = vmask_q >> (32'(k) << (32'(2) - 32'(sew_q)));
              case (sew_q)
                2'd0:    be = mw[3:0];
                2'd1:    be = {{2{mw[1]}}, {2{mw[0]}}};
                default: be = {4{mw[0]}};
              endcase
`endif
              for (int b = 0; b < NUM_BANKS; b++) begin
                if (ADDR_BITS'(b) == bk && be != 4'h0) begin
                  bank_we[b]                       = 1'b1;
                  bank_addr[b*ADDR_BITS +: ADDR_BITS] = a;
                  bank_wdata[b*32 +: 32]           = word;
                  bank_be[b*4 +: 4]                = be;
                end
              end
              cnt = cnt + CW'(1);
            end
          end
        end else begin
          // Greedy packing: stop at the first element whose bank is already taken this cycle.
          for (int j = 0; j < NUM_BANKS; j++) begin
            k = idx_q + CW'(j);
            if (!stop && k < total_q) begin
              bk = a & BMASK;
              en = 1'b1;
`ifdef VSU_MASK_EN
              mw = vmask_q >> k;
              en = mw[0];
`endif
              hit = 1'b0;
              for (int b = 0; b < NUM_BANKS; b++)
                if (ADDR_BITS'(b) == bk && used[b]) hit = 1'b1;
              if (en && hit) begin
                stop = 1'b1;
              end else begin
                if (en) begin
                  word = get_elem(data_q, sew_q, k);
                  be   = (sew_q == 2'd0) ? 4'h1 : (sew_q == 2'd1) ? 4'h3 : 4'hF;
                  for (int b = 0; b < NUM_BANKS; b++) begin
                    if (ADDR_BITS'(b) == bk) begin
                      used[b]                          = 1'b1;
                      bank_we[b]                       = 1'b1;
                      bank_addr[b*ADDR_BITS +: ADDR_BITS] = a;
                      bank_wdata[b*32 +: 32]           = word;
                      bank_be[b*4 +: 4]                = be;
                    end
                  end
                end
                cnt = cnt + CW'(1);
                a   = a + stride_q;
              end
            end
          end
        end
        if (!mem_stall) begin
          idx_d = idx_q + cnt;
          if (!unit_q) addr_d = a;
          if (idx_d >= total_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_v_store_seq.sv
// Randomized self-checking bench for v_store_seq against a per-element scheduling model.
module tb_v_store_seq;
  localparam int VLEN = 128;
  localparam int NB   = 4;
  localparam int AB   = 16;
  localparam int VW   = NB + NB*AB + NB*32 + NB*4;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        store_op = '0;
  logic [2:0]        vsew = '0;
  logic [2:0]        lmul = '0;
  logic [AB-1:0]     base_addr = '0;
  logic [AB-1:0]     stride = '0;
  logic [4*VLEN-1:0] data = '0;
  logic              mem_stall = 1'b0;
  logic [NB-1:0]     bank_we;
  logic [NB*AB-1:0]  bank_addr;
  logic [NB*32-1:0]  bank_wdata;
  logic [NB*4-1:0]   bank_be;
  logic              busy, done, err;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [VW-1:0] exp_q[$];

  v_store_seq #(.VLEN(VLEN), .NUM_BANKS(NB), .ADDR_BITS(AB)) dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
    .store_op(store_op), .vsew(vsew), .lmul(lmul), .base_addr(base_addr),
    .stride(stride), .data(data), .mem_stall(mem_stall), .bank_we(bank_we),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_be(bank_be),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference: list every write with its address, then pack into cycles per the bank rule.
  task automatic model(input int op, input int sew_code, input int lmul_code,
                       input logic [AB-1:0] base, input logic [AB-1:0] str,
                       input logic [4*VLEN-1:0] d);
    int sew, n, cnt, b;
    logic [NB-1:0]     we;
    logic [NB*AB-1:0]  ad;
    logic [NB*32-1:0]  wd;
    logic [NB*4-1:0]   bes;
    logic [AB-1:0]     a;
    logic [31:0]       e;
    logic [3:0]        be;
    logic [4*VLEN-1:0] t;
    exp_q.delete();
    sew = 8 << sew_code;
    n   = (op == 0) ? ((VLEN/32) << lmul_code) : ((VLEN/sew) << lmul_code);
    we = '0; ad = '0; wd = '0; bes = '0; cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (op == 0) begin
        a  = base + AB'(i);
        t  = d >> (i*32);
        e  = t[31:0];
        be = 4'hF;
      end else begin
        a  = base + AB'(i) * str;
        t  = d >> (i*sew);
        e  = t[31:0];
        if (sew < 32) e = e & ((32'd1 << sew) - 32'd1);
        be = (sew == 8) ? 4'h1 : (sew == 16) ? 4'h3 : 4'hF;
      end
      b = int'(a) % NB;
      if (we[b] || cnt == NB) begin
        exp_q.push_back({we, ad, wd, bes});
        we = '0; ad = '0; wd = '0; bes = '0; cnt = 0;
      end
      we[b] = 1'b1; ad[b*AB +: AB] = a; wd[b*32 +: 32] = e; bes[b*4 +: 4] = be;
      cnt++;
    end
    if (cnt > 0) exp_q.push_back({we, ad, wd, bes});
  endtask

  function automatic logic [4*VLEN-1:0] rand_data();
    logic [4*VLEN-1:0] d;
    for (int i = 0; i < 4*VLEN/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // stall_mode: 0 none, 1 random, 2 three stalled cycles after the first write cycle
  task automatic run_req(input string tag, input int op, input int sew_code, input int lmul_code,
                         input logic [AB-1:0] base, input logic [AB-1:0] str,
                         input logic [4*VLEN-1:0] d, input int stall_mode, input logic exp_err);
    int guard;
    if (exp_err) exp_q.delete();
    else model(op, sew_code, lmul_code, base, str, d);
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready"}, 256'(req_ready), 256'(1));
    req_valid = 1'b1; store_op = 2'(op); vsew = 3'(sew_code); lmul = 3'(lmul_code);
    base_addr = base; stride = str; data = d;
    @(negedge clk);
    req_valid = 1'b0;
    data = ~d;
    guard = 0;
    while (exp_q.size() > 0 && guard < 400) begin
      check({tag, " bank"}, 256'({req_ready, busy, done, bank_we, bank_addr, bank_wdata, bank_be}),
            256'({3'b010, exp_q[0]}));
      case (stall_mode)
        1:       mem_stall = ($urandom_range(0, 3) == 0);
        2:       mem_stall = (guard >= 1 && guard <= 3);
        default: mem_stall = 1'b0;
      endcase
      if (!mem_stall) void'(exp_q.pop_front());
      guard++;
      @(negedge clk);
    end
    mem_stall = 1'b0;
    if (exp_q.size() > 0) check({tag, " timeout"}, 256'(exp_q.size()), 256'(0));
    check({tag, " done"}, 256'({req_ready, busy, done, err, bank_we}), 256'({3'b011, exp_err, 4'b0}));
    @(negedge clk);
    check({tag, " idle"}, 256'({req_ready, busy, done, err, dbg_state}), 256'({4'b1000, 2'd0}));
  endtask

  initial begin
    logic [4*VLEN-1:0] d;
    int op, sw, lm;
    logic [AB-1:0] st;
    #1;
    check("reset", 256'({req_ready, busy, done, err, dbg_state, bank_we, bank_addr, bank_wdata, bank_be}),
          256'({4'b1000, 2'd0, {VW{1'b0}}}));
    @(negedge clk);
    nrst = 1'b1;

    run_req("unit_sew32", 0, 2, 0, 16'h0010, 16'h0000, rand_data(), 0, 1'b0);
    run_req("str_sew8_s4", 1, 0, 0, 16'h0000, 16'h0004, rand_data(), 0, 1'b0);
    run_req("str_sew32_s3", 1, 2, 1, 16'h0001, 16'h0003, rand_data(), 0, 1'b0);
    run_req("unit_stall", 0, 2, 2, 16'h0102, 16'h0000, rand_data(), 2, 1'b0);
    run_req("str_s0", 1, 1, 0, 16'h0007, 16'h0000, rand_data(), 0, 1'b0);
    run_req("str_neg", 1, 0, 1, 16'h0003, 16'hFFFF, rand_data(), 1, 1'b0);
    run_req("str_wrap", 1, 2, 0, 16'hFFFE, 16'h0005, rand_data(), 0, 1'b0);

    // Abort mid-issue; outputs must clear while nrst is still low.
    req_valid = 1'b1; store_op = 2'd0; vsew = 3'd2; lmul = 3'd2; base_addr = 16'h0040; data = rand_data();
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("abort", 256'({req_ready, busy, done, err, dbg_state, bank_we, bank_addr, bank_wdata, bank_be}),
          256'({4'b1000, 2'd0, {VW{1'b0}}}));
    @(negedge clk);
    nrst = 1'b1;
    run_req("after_rst", 0, 0, 2, 16'h0203, 16'h0000, rand_data(), 0, 1'b0);
    run_req("bad_sew", 0, 3, 0, 16'h0000, 16'h0000, rand_data(), 0, 1'b1);
    run_req("bad_op", 2, 0, 0, 16'h0000, 16'h0000, rand_data(), 0, 1'b1);
    run_req("bad_lmul", 1, 1, 3, 16'h0000, 16'h0001, rand_data(), 0, 1'b1);

    for (int r = 0; r < 16; r++) begin
      op = $urandom_range(0, 1);
      sw = $urandom_range(0, 2);
      lm = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       st = 16'h0000;
        1:       st = AB'($urandom_range(1, 9));
        2:       st = -AB'($urandom_range(1, 9));
        default: st = AB'($urandom);
      endcase
      d = rand_data();
      run_req("rand", op, sw, lm, AB'($urandom), st, d, 1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/v_store_seq.md
V_STORE_SEQ -- requirements
Module: v_store_seq

Interface
REQ-001 Parameter VLEN, default 128, vector register width in bits (multiple of 32).
REQ-002 Parameter NUM_BANKS, default 4, number of 32-bit data-memory banks (power of 2, 1..8).
REQ-003 Parameter ADDR_BITS, default `DATAMEM_BITS, word-address width.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 nrst  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1 / req_ready  out  1  request handshake; accepted when both high at posedge.
REQ-007 store_op  in  2  0 unit-stride, 1 strided, 2/3 reserved.
REQ-008 vsew  in  3  000 SEW8, 001 SEW16, 010 SEW32; other values reserved. lmul  in  3  000 x1, 001 x2, 010 x4; other values reserved.
REQ-009 base_addr  in  ADDR_BITS  word address of element 0; stride  in  ADDR_BITS  signed word stride.
REQ-010 data  in  4*VLEN  register-group data, element 0 in LSBs; sampled only on accept.
REQ-011 bank_we  out  NUM_BANKS; bank_addr  out  NUM_BANKS*ADDR_BITS; bank_wdata  out  NUM_BANKS*32; bank_be  out  NUM_BANKS*4.
REQ-012 mem_stall  in  1  memory back-pressure; busy  out  1; done  out  1; err  out  1.

Function
REQ-013 FSM states: IDLE, ISSUE, DONE; req_ready SHALL be 1 only in IDLE.
REQ-014 On accept: latch all inputs, go to ISSUE; first bank write appears in the next cycle.
REQ-015 Element count N = (VLEN/SEW)*LMUL; reserved vsew/lmul/store_op SHALL go to DONE directly with err=1 and no writes.
REQ-016 Unit-stride: write words W = N*SEW/32 in order; word k goes to address base_addr+k, bank (base_addr+k) mod NUM_BANKS, be=4'hF; NUM_BANKS words per cycle; last cycle may be partial.
REQ-017 Strided: element i goes to word address base_addr+i*stride (mod 2^ADDR_BITS), bank = address mod NUM_BANKS; wdata = element zero-extended; be = 0001/0011/1111 for SEW8/16/32.
REQ-018 Strided issue: each cycle issue consecutive elements in order, stopping before the first element whose bank is already used this cycle, or after NUM_BANKS elements; stride 0 SHALL yield 1 element per cycle.
REQ-019 Unused banks in a cycle SHALL drive we=0, addr=0, wdata=0, be=0.
REQ-020 mem_stall=1: all bank outputs and progress held; no element skipped or duplicated on release.
REQ-021 After the last element issues, enter DONE for exactly one cycle: done=1 (and err if applicable), then IDLE.
REQ-022 busy=1 in ISSUE and DONE.

Reset
REQ-023 nrst low SHALL immediately force IDLE, req_ready=1, busy=0, done=0, err=0, all bank outputs 0, counters 0, including mid-operation; the aborted request is not resumed.
REQ-024 First accept SHALL be possible on the first posedge after nrst deasserts.

Configuration
REQ-025 Macro VSU_MASK_EN: when defined, adds input vmask (4*VLEN/8 bits, bit i = element i) latched on accept; masked-off elements retire without using a bank slot (strided) or clear their byte lanes in be (unit-stride; word with be=0 drives we=0). When undefined, port absent and all elements write.

Verification
REQ-026 Unit-stride SEW32 LMUL1, base 0x10, NUM_BANKS 4 -> one write cycle, addr 0x10..0x13, be=F all banks, done 2 cycles after accept.
REQ-027 Strided SEW8 LMUL1, stride 4, base 0 -> 16 cycles, one element/cycle on bank 0, be=0001, done after cycle 16.
REQ-028 Strided SEW32 LMUL2, stride 3, base 1 -> 8 elements, 2 cycles of 4 writes, bank order 1,0,3,2.
REQ-029 mem_stall high 3 cycles during unit-stride LMUL4 -> outputs frozen, 4 write cycles total, data intact.
REQ-030 nrst low during ISSUE of LMUL4 store -> all outputs 0 same cycle; new request after release completes normally; vsew=011 request -> done=1, err=1, no we.
